multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencer for the MIPS CPU: one registered FSM steps a shared datapath (single ALU, unified memory, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and writeback. It replaces per-instruction combinational control when the datapath is multi-cycle. It decodes the same instruction subset as the single-cycle CPU, uses ALU op codes from `ctrl_encode_def.v`, and talks to memory through a req/ready handshake.

## Interface
- TIMEOUT, 255: maximum wait cycles in a memory state; 0 disables the timeout.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ir  in  32  instruction register contents; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write request (sw)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory dout
- pc_write  out  1  PC write enable
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], imm26, 2'b00}, 3 = A
- alu_src_a  out  2  0 = PC, 1 = A, 2 = shamt
- alu_src_b  out  2  0 = B, 1 = 4, 2 = imm32, 3 = imm32<<2
- alu_op  out  4  `ALU_*` code
- reg_write  out  1  RF write enable
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- reg_src  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- state  out  3  current state, for debug
- illegal  out  1  one-cycle pulse: undecodable instruction
- timeout  out  1  one-cycle pulse: memory wait expired

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 are unreachable and go to FETCH.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ALU_ADD, pc_src=0.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle moves to DECODE.
- DECODE: computes the branch target (alu_src_a=0, alu_src_b=3, ALU_ADD) into ALUOut.
  - Unsupported opcode/funct: pulse illegal, go to FETCH with no writes.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: alu_src_a=1, or 2 for sll/srl/sra; alu_src_b=0; funct mapping as in the single-cycle decoder.
  - I-type ALU (addi/slti/andi/ori/lui) and lw/sw: alu_src_a=1, alu_src_b=2.
  - beq/bne: ALU_SUB on A,B; pc_src=1; pc_write = zero (beq) or !zero (bne); then FETCH.
  - j: pc_write=1, pc_src=2; then FETCH.
  - jal: j, plus reg_write=1, reg_dst=2, reg_src=2; then FETCH.
  - jr: pc_write=1, pc_src=3; then FETCH.
  - jalr: jr, plus reg_write=1, reg_dst=1, reg_src=2; then FETCH.
  - lw/sw: next state MEM. R/I ALU ops: next state WB.
- MEM: mem_req=1, i_or_d=1, mem_we = (sw).
  - Wait for mem_ready.
  - sw: then FETCH. lw: then WB.
- WB: reg_write=1.
  - R-type: reg_dst=1, reg_src=0.
  - I-type: reg_dst=0, reg_src=0.
  - lw: reg_dst=0, reg_src=1.
  - Then FETCH.
- Outputs not listed for a state are 0.
- The link value uses PC, already advanced in FETCH, so it equals instruction address + 4.
- Timeout: a wait counter, TIMEOUT bits wide enough, clears on entry to FETCH/MEM.
  - It counts cycles with mem_req=1 and mem_ready=0.
  - On reaching TIMEOUT: pulse timeout, go to FETCH, no PC/IR/RF write.
  - mem_req is 0 for that cycle.

## Timing
- Reset: state=FETCH, counters 0. While rst=1, every output is forced to 0, including mem_req.
- First request appears in the first cycle after rst falls.
- Reset mid-access aborts at once; the memory must drop the pending access.
- Cycles per instruction, zero-wait memory:
  - beq/bne/j/jal/jr/jalr: 3
  - R/I ALU and sw: 4
  - lw: 5
  - Each memory wait adds 1.
- mem_req, mem_we and i_or_d are stable from assertion until the mem_ready cycle.
- mem_ready is ignored when mem_req=0.
- pc_write/ir_write/reg_write are combinational from state, ir, zero and mem_ready, and take effect at the next clk edge.

## Configuration
- MCTRL_PERF_EN defined: adds output cycle_cnt[31:0] and output instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each transition into FETCH from a non-FETCH state that is not an illegal or timeout exit.
  - Both wrap 0xFFFFFFFF→0.
- MCTRL_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then ir=add $3,$1,$2 (0x00221820), mem_ready=1 → states 0,1,2,4; reg_write=1 in WB with reg_dst=1; next FETCH at cycle 5.
- lw (0x8C220004) with mem_ready low for 2 MEM cycles → MEM held 3 cycles with i_or_d=1, mem_we=0; WB reg_src=1; CPI=7.
- beq (0x10220003) with zero=1, then zero=0 → pc_write=1/pc_src=1 in EXEC, then pc_write=0; 3 cycles each.
- jal (0x0C000010) → EXEC: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, reg_src=2.
- Opcode 0x3F → illegal pulse in DECODE, no writes, FETCH next; with TIMEOUT=4 and mem_ready stuck at 0 → timeout after 4 wait cycles, no pc_write.
- rst asserted mid-MEM → all outputs 0 immediately; FETCH after release; with MCTRL_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// datapath plus unified memory (slave).
interface multicycle_control_if;
  logic [31:0] ir;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  reg_src;
  logic [2:0]  state;
  logic        illegal;
  logic        timeout;

  modport master (
    input  ir, zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, reg_src,
           state, illegal, timeout
  );

  modport slave (
    output ir, zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, reg_src,
           state, illegal, timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with memory-wait timeout.
// Optional MCTRL_PERF_EN adds free-running cycle_cnt and retired instr_cnt outputs.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
`ifdef MCTRL_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  multicycle_control_if.master bus
);

  localparam logic [3:0] ALU_NOP  = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,
                         ALU_AND  = 4'd3,  ALU_OR  = 4'd4,  ALU_SLT = 4'd5,
                         ALU_SLTU = 4'd6,  ALU_XOR = 4'd7,  ALU_NOR = 4'd8,
                         ALU_SLL  = 4'd9,  ALU_SRL = 4'd10, ALU_SRA = 4'd11,
                         ALU_LUI  = 4'd12;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03,
                         F_JR  = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_V = CW'(TIMEOUT);

  typedef enum logic [3:0] {
    C_NONE, C_RALU, C_RSH, C_JR, C_JALR, C_IALU,
    C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
  } cls_t;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  cls_t          cls;
  logic [3:0]    ex_op;
  logic          mem_state;
  logic          tmo_hit;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo_hit   = (TIMEOUT != 0) && mem_state && (wait_q == TMO_V);

  // Instruction class and EXEC-stage ALU op.
  always_comb begin
    cls   = C_NONE;
    ex_op = ALU_NOP;
    case (bus.ir[31:26])
      OP_RTYPE: begin
        case (bus.ir[5:0])
          F_ADD, F_ADDU: begin cls = C_RALU; ex_op = ALU_ADD;  end
          F_SUB, F_SUBU: begin cls = C_RALU; ex_op = ALU_SUB;  end
          F_AND:         begin cls = C_RALU; ex_op = ALU_AND;  end
          F_OR:          begin cls = C_RALU; ex_op = ALU_OR;   end
          F_XOR:         begin cls = C_RALU; ex_op = ALU_XOR;  end
          F_NOR:         begin cls = C_RALU; ex_op = ALU_NOR;  end
          F_SLT:         begin cls = C_RALU; ex_op = ALU_SLT;  end
          F_SLTU:        begin cls = C_RALU; ex_op = ALU_SLTU; end
          F_SLL:         begin cls = C_RSH;  ex_op = ALU_SLL;  end
          F_SRL:         begin cls = C_RSH;  ex_op = ALU_SRL;  end
          F_SRA:         begin cls = C_RSH;  ex_op = ALU_SRA;  end
          F_JR:          cls = C_JR;
          F_JALR:        cls = C_JALR;
          default:       ;
        endcase
      end
      OP_ADDI: begin cls = C_IALU; ex_op = ALU_ADD; end
      OP_SLTI: begin cls = C_IALU; ex_op = ALU_SLT; end
      OP_ANDI: begin cls = C_IALU; ex_op = ALU_AND; end
      OP_ORI:  begin cls = C_IALU; ex_op = ALU_OR;  end
      OP_LUI:  begin cls = C_IALU; ex_op = ALU_LUI; end
      OP_LW:   begin cls = C_LW;   ex_op = ALU_ADD; end
      OP_SW:   begin cls = C_SW;   ex_op = ALU_ADD; end
      OP_BEQ:  begin cls = C_BEQ;  ex_op = ALU_SUB; end
      OP_BNE:  begin cls = C_BNE;  ex_op = ALU_SUB; end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = (!tmo_hit && bus.mem_ready) ? S_DECODE : S_FETCH;
      S_DECODE: state_d = (cls == C_NONE) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (cls == C_LW || cls == C_SW)
          state_d = S_MEM;
        else if (cls == C_RALU || cls == C_RSH || cls == C_IALU)
          state_d = S_WB;
        else
          state_d = S_FETCH;
      end
      S_MEM: begin
        if (tmo_hit || !bus.mem_ready)
          state_d = tmo_hit ? S_FETCH : S_MEM;
        else
          state_d = (cls == C_SW) ? S_FETCH : S_WB;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts with every new memory access.
  always_comb begin
    wait_d = wait_q;
    if (tmo_hit || ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)))
      wait_d = '0;
    else if (mem_state && !bus.mem_ready)
      wait_d = wait_q + 1'b1;
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.i_or_d    = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 2'd0;
    bus.alu_src_a = 2'd0;
    bus.alu_src_b = 2'd0;
    bus.alu_op    = ALU_NOP;
    bus.reg_write = 1'b0;
    bus.reg_dst   = 2'd0;
    bus.reg_src   = 2'd0;
    bus.state     = 3'd0;
    bus.illegal   = 1'b0;
    bus.timeout   = 1'b0;
    if (!rst) begin
      bus.state   = state_q;
      bus.timeout = tmo_hit;
      case (state_q)
        S_FETCH: begin
          bus.mem_req   = !tmo_hit;
          bus.alu_src_b = 2'd1;
          bus.alu_op    = ALU_ADD;
          bus.ir_write  = !tmo_hit && bus.mem_ready;
          bus.pc_write  = !tmo_hit && bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'd3;
          bus.alu_op    = ALU_ADD;
          bus.illegal   = (cls == C_NONE);
        end
        S_EXEC: begin
          case (cls)
            C_RALU: begin bus.alu_src_a = 2'd1; bus.alu_op = ex_op; end
            C_RSH:  begin bus.alu_src_a = 2'd2; bus.alu_op = ex_op; end
            C_IALU, C_LW, C_SW: begin
              bus.alu_src_a = 2'd1;
              bus.alu_src_b = 2'd2;
              bus.alu_op    = ex_op;
            end
            C_BEQ, C_BNE: begin
              bus.alu_src_a = 2'd1;
              bus.alu_op    = ex_op;
              bus.pc_src    = 2'd1;
              bus.pc_write  = (cls == C_BEQ) ? bus.zero : !bus.zero;
            end
            C_J, C_JAL: begin
              bus.pc_write  = 1'b1;
              bus.pc_src    = 2'd2;
              bus.reg_write = (cls == C_JAL);
              bus.reg_dst   = (cls == C_JAL) ? 2'd2 : 2'd0;
              bus.reg_src   = (cls == C_JAL) ? 2'd2 : 2'd0;
            end
            C_JR, C_JALR: begin
              bus.pc_write  = 1'b1;
              bus.pc_src    = 2'd3;
              bus.reg_write = (cls == C_JALR);
              bus.reg_dst   = (cls == C_JALR) ? 2'd1 : 2'd0;
              bus.reg_src   = (cls == C_JALR) ? 2'd2 : 2'd0;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req = !tmo_hit;
          bus.i_or_d  = !tmo_hit;
          bus.mem_we  = !tmo_hit && (cls == C_SW);
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = (cls == C_RALU || cls == C_RSH) ? 2'd1 : 2'd0;
          bus.reg_src   = (cls == C_LW) ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef MCTRL_PERF_EN
  logic [31:0] cycle_q, instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      // Retire only on a normal return to FETCH, not on illegal/timeout aborts.
      if (state_q != S_FETCH && state_d == S_FETCH && !bus.illegal && !bus.timeout)
        instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`endif

endmodule
